// File: rtl/cttest_core.sv
// Register-mapped bring-up core: version/status/operand/result/scratch registers
// and a sequential add/xor/shift-add multiply engine behind a start/ready handshake.
module cttest_core #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_SCRATCH = 4,
  parameter logic [31:0] VERSION     = 32'h63747432
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic [3:0]            address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  api_error
);
  localparam int          CW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [31:0] VER     = VERSION;
  localparam logic [1:0]  OP_ADD  = 2'b00;
  localparam logic [1:0]  OP_XOR  = 2'b01;
  localparam logic [1:0]  OP_MUL  = 2'b10;
  localparam logic [1:0]  OP_RSV  = 2'b11;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_reg, state_next;
  logic                  ready;
  logic                  busy;
  logic [1:0]            op_reg;
  logic [CW-1:0]         cnt_reg;
  logic [DATA_WIDTH-1:0] opa_reg, opb_reg, res_lo_reg, res_hi_reg, cycles_reg;
  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] scratch_val [NUM_SCRATCH];

  logic                  is_scratch, is_mapped, wr_err, wr_ok, start_ok, finish;
  logic [DATA_WIDTH:0]   add_sum, mul_sum;

  assign busy       = (state_reg == BUSY);
  assign is_scratch = (int'(address) >= 8) && (int'(address) < 8 + NUM_SCRATCH);
  assign is_mapped  = (address < 4'h8) || is_scratch;

  always_comb begin
    wr_err = 1'b0;
    case (address)
      4'h0, 4'h2, 4'h5, 4'h6, 4'h7: wr_err = 1'b1;
      4'h1:                         wr_err = write_data[0] && ((write_data[2:1] == OP_RSV) || busy);
      4'h3, 4'h4:                   wr_err = busy;
      default:                      wr_err = !is_scratch;
    endcase
  end

  assign api_error = cs && (we ? wr_err : !is_mapped);
  assign wr_ok     = cs && we && !wr_err;
  assign start_ok  = wr_ok && (address == 4'h1) && write_data[0];
  assign finish    = busy && (cnt_reg == '0);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = BUSY;
      BUSY:    if (cnt_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = (state_reg == IDLE);
  end

  assign add_sum = {1'b0, opa_reg} + {1'b0, opb_reg};
  // Multiply: res_hi accumulates, res_lo holds the unconsumed multiplier bits
  // and fills with product bits from the top as the pair shifts right.
  assign mul_sum = {1'b0, res_hi_reg} + (res_lo_reg[0] ? {1'b0, opa_reg} : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg     <= OP_ADD;
      cnt_reg    <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      res_lo_reg <= '0;
      res_hi_reg <= '0;
      cycles_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (wr_ok && address == 4'h3) begin
        opa_reg   <= write_data;
        valid_reg <= 1'b0;
      end
      if (wr_ok && address == 4'h4) begin
        opb_reg   <= write_data;
        valid_reg <= 1'b0;
      end
      if (start_ok) begin
        op_reg     <= write_data[2:1];
        cnt_reg    <= (write_data[2:1] == OP_MUL) ? CW'(DATA_WIDTH - 1) : '0;
        cycles_reg <= '0;
        valid_reg  <= 1'b0;
        if (write_data[2:1] == OP_MUL) begin
          res_hi_reg <= '0;
          res_lo_reg <= opb_reg;
        end
      end else if (busy) begin
        if (cycles_reg != '1) cycles_reg <= cycles_reg + 1'b1;
        if (cnt_reg != '0)    cnt_reg    <= cnt_reg - 1'b1;
        if (finish)           valid_reg  <= 1'b1;
        case (op_reg)
          OP_ADD: begin
            res_lo_reg <= add_sum[DATA_WIDTH-1:0];
            res_hi_reg <= {{(DATA_WIDTH-1){1'b0}}, add_sum[DATA_WIDTH]};
          end
          OP_XOR: begin
            res_lo_reg <= opa_reg ^ opb_reg;
            res_hi_reg <= '0;
          end
          default: begin
            res_hi_reg <= mul_sum[DATA_WIDTH:1];
            res_lo_reg <= {mul_sum[0], res_lo_reg[DATA_WIDTH-1:1]};
          end
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
      logic [DATA_WIDTH-1:0] value_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          value_reg <= '0;
        else if (wr_ok && is_scratch && address[2:0] == 3'(gi))
          value_reg <= write_data;
      end
      assign scratch_val[gi] = value_reg;
    end
  endgenerate

  always_comb begin
    read_data = '0;
    if (cs) begin
      case (address)
        4'h0: read_data = VER[DATA_WIDTH-1:0];
        4'h2: read_data = {{(DATA_WIDTH-2){1'b0}}, valid_reg, ready};
        4'h3: read_data = opa_reg;
        4'h4: read_data = opb_reg;
        4'h5: read_data = res_lo_reg;
        4'h6: read_data = res_hi_reg;
        4'h7: read_data = cycles_reg;
        default: begin
          for (int i = 0; i < NUM_SCRATCH; i++)
            if (is_scratch && address[2:0] == 3'(i)) read_data = scratch_val[i];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cttest_core.sv
// Directed bench for cttest_core: reset state, add/xor/mul, busy rejections,
// illegal accesses and asynchronous abort.
module tb_cttest_core;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  address = 4'h0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        api_error;

  int vectors = 0;
  int miscompares = 0;

  cttest_core dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .api_error(api_error)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output logic err);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    #1 err = api_error;
    $display("wr addr=%h data=%h err=%b", a, d, err);
    @(posedge clk);
    #1 cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic err);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    #1 d = read_data; err = api_error;
    $display("rd addr=%h data=%h err=%b", a, d, err);
    @(posedge clk);
    #1 cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    logic [3:0]  addrs [6] = '{4'h0, 4'h2, 4'h3, 4'h5, 4'h7, 4'h8};
    logic [31:0] exps  [6] = '{32'h63747432, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    #1;
    vectors++;
    if (read_data !== 32'h0 || api_error !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_bus: data=%h err=%b required data=0 err=0", read_data, api_error);
    end
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], d, e);
      vectors++;
      if (d !== exps[i] || e !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_read_%h: data=%h err=%b required data=%h err=0", addrs[i], d, e, exps[i]);
      end
    end
  endtask

  task automatic test_add_xor();
    logic [31:0] d; logic e;
    logic [31:0] ctrl [2]   = '{32'h1, 32'h3};
    logic [31:0] exp_lo [2] = '{32'h0, 32'hFFFFFFFE};
    logic [31:0] exp_hi [2] = '{32'h1, 32'h0};
    bus_write(4'h3, 32'hFFFFFFFF, e);
    bus_write(4'h4, 32'h00000001, e);
    for (int i = 0; i < 2; i++) begin
      bus_write(4'h1, ctrl[i], e);
      vectors++;
      if (e !== 1'b0) begin miscompares++; $display("FAIL start_%0d_err: got %b required 0", i, e); end
      bus_read(4'h2, d, e);
      vectors++;
      if (d !== 32'h0) begin miscompares++; $display("FAIL status_busy_%0d: got %h required 0", i, d); end
      bus_read(4'h2, d, e);
      vectors++;
      if (d !== 32'h3) begin miscompares++; $display("FAIL status_done_%0d: got %h required 3", i, d); end
      bus_read(4'h5, d, e);
      vectors++;
      if (d !== exp_lo[i]) begin miscompares++; $display("FAIL res_lo_%0d: got %h required %h", i, d, exp_lo[i]); end
      bus_read(4'h6, d, e);
      vectors++;
      if (d !== exp_hi[i]) begin miscompares++; $display("FAIL res_hi_%0d: got %h required %h", i, d, exp_hi[i]); end
      bus_read(4'h7, d, e);
      vectors++;
      if (d !== 32'h1) begin miscompares++; $display("FAIL cycles_%0d: got %h required 1", i, d); end
    end
  endtask

  task automatic test_mul_busy();
    logic [31:0] d; logic e;
    int busy_cycles;
    bit done;
    bus_write(4'h3, 32'hFFFFFFFF, e);
    bus_write(4'h4, 32'hFFFFFFFF, e);
    bus_write(4'h1, 32'h5, e);
    bus_write(4'h1, 32'h1, e);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL start_while_busy: err=%b required 1", e); end
    bus_write(4'h3, 32'h5, e);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL opa_while_busy: err=%b required 1", e); end
    bus_write(4'h8, 32'hA5A5A5A5, e);
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL scratch_write_busy: err=%b required 0", e); end
    bus_read(4'h8, d, e);
    vectors++;
    if (d !== 32'hA5A5A5A5 || e !== 1'b0) begin
      miscompares++; $display("FAIL scratch_readback: data=%h err=%b required a5a5a5a5 err=0", d, e);
    end
    busy_cycles = 4;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      bus_read(4'h2, d, e);
      if (d[0]) done = 1; else busy_cycles++;
    end
    vectors++;
    if (!done || busy_cycles != 32 || d !== 32'h3) begin
      miscompares++;
      $display("FAIL mul_busy_len: busy=%0d status=%h done=%0d required busy=32 status=3", busy_cycles, d, done);
    end
    bus_read(4'h6, d, e);
    vectors++;
    if (d !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL mul_hi: got %h required fffffffe", d); end
    bus_read(4'h5, d, e);
    vectors++;
    if (d !== 32'h00000001) begin miscompares++; $display("FAIL mul_lo: got %h required 00000001", d); end
    bus_read(4'h7, d, e);
    vectors++;
    if (d !== 32'd32) begin miscompares++; $display("FAIL mul_cycles: got %h required 20", d); end
    bus_read(4'h3, d, e);
    vectors++;
    if (d !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL opa_kept: got %h required ffffffff", d); end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic e;
    bus_write(4'h0, 32'h12345678, e);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL write_ro: err=%b required 1", e); end
    bus_write(4'h1, 32'h7, e);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL ctrl_reserved: err=%b required 1", e); end
    bus_read(4'hF, d, e);
    vectors++;
    if (e !== 1'b1 || d !== 32'h0) begin
      miscompares++; $display("FAIL unmapped_read: data=%h err=%b required data=0 err=1", d, e);
    end
    bus_write(4'h1, 32'h4, e);
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL ctrl_noop: err=%b required 0", e); end
    bus_read(4'h0, d, e);
    vectors++;
    if (d !== 32'h63747432) begin miscompares++; $display("FAIL version_kept: got %h required 63747432", d); end
    bus_read(4'h2, d, e);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("FAIL status_kept: got %h required 3", d); end
    bus_read(4'h5, d, e);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL res_lo_kept: got %h required 1", d); end
  endtask

  task automatic test_async_abort();
    logic [31:0] d; logic e;
    logic [3:0]  addrs [6] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    logic [31:0] exps  [6] = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    bus_write(4'h3, 32'd3, e);
    bus_write(4'h4, 32'd5, e);
    bus_write(4'h1, 32'h5, e);
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    cs = 1'b1; we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      address = addrs[i];
      #0.5;
      $display("rd_in_reset addr=%h data=%h err=%b", addrs[i], read_data, api_error);
      vectors++;
      if (read_data !== exps[i]) begin
        miscompares++;
        $display("FAIL abort_%h: got %h required %h", addrs[i], read_data, exps[i]);
      end
    end
    cs = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      bus_read(addrs[i], d, e);
      vectors++;
      if (d !== exps[i]) begin
        miscompares++;
        $display("FAIL post_abort_%h: got %h required %h", addrs[i], d, exps[i]);
      end
    end
  endtask

  initial begin
    #12 reset_n = 1'b1;
    test_reset();
    test_add_xor();
    test_mul_busy();
    test_illegal();
    test_async_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
